// File: rtl/counter_datachk.sv
// Receive-side checker for the 8-bit incrementing counter stream: finds the bit rotation that
// aligns the words, tracks lock, and counts word/bit errors while locked.
module counter_datachk #(
    parameter int unsigned LOCK_THRESH   = 16,
    parameter int unsigned UNLOCK_THRESH = 4,
    parameter int unsigned ERR_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_data_valid,
    input  logic [7:0]       i_data_in,
    input  logic             i_clear,
    output logic             o_locked,
    output logic [2:0]       o_rot,
    output logic [ERR_W-1:0] o_word_err_cnt,
    output logic [ERR_W-1:0] o_bit_err_cnt,
    output logic [7:0]       o_lock_loss_cnt,
    output logic             o_err_pulse
);

    typedef enum logic {StSearch, StLocked} state_e;

    // Sum is wide enough for an ERR_W count plus a popcount of up to 8.
    localparam int unsigned SUM_W = ((ERR_W > 4) ? ERR_W : 4) + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_e           r_state;
    logic [2:0]       r_rot;
    logic             r_have_prev;
    logic [7:0]       r_prev;
    logic [7:0]       r_match_cnt;
    logic [7:0]       r_miss_cnt;
    logic [7:0]       r_expected;
    logic [ERR_W-1:0] r_word_err;
    logic [ERR_W-1:0] r_bit_err;
    logic [7:0]       r_lock_loss;
    logic             r_err_pulse;

    logic [15:0]      w_dbl;
    logic [7:0]       w_aligned;
    logic [7:0]       w_diff;
    logic [3:0]       w_popcnt;
    logic [SUM_W-1:0] w_bit_sum;
    logic [ERR_W-1:0] w_bit_next;
    logic [ERR_W-1:0] w_word_next;
    logic [7:0]       w_match_inc;
    logic [7:0]       w_miss_inc;

    // Rotate-left: the upper byte of the doubled word shifted by rot.
    assign w_dbl     = {i_data_in, i_data_in} << r_rot;
    assign w_aligned = w_dbl[15:8];
    assign w_diff    = w_aligned ^ r_expected;

    always_comb begin
        w_popcnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_popcnt = w_popcnt + 4'(w_diff[i]);
        end
    end

    assign w_bit_sum   = SUM_W'(r_bit_err) + SUM_W'(w_popcnt);
    assign w_bit_next  = (w_bit_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : w_bit_sum[ERR_W-1:0];
    assign w_word_next = (r_word_err == ERR_MAX) ? r_word_err : r_word_err + ERR_W'(1);
    assign w_match_inc = r_match_cnt + 8'd1;
    assign w_miss_inc  = r_miss_cnt + 8'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StSearch;
            r_rot       <= 3'd0;
            r_have_prev <= 1'b0;
            r_prev      <= 8'd0;
            r_match_cnt <= 8'd0;
            r_miss_cnt  <= 8'd0;
            r_expected  <= 8'd0;
            r_word_err  <= '0;
            r_bit_err   <= '0;
            r_lock_loss <= 8'd0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (i_data_valid) begin
                unique case (r_state)
                    StSearch: begin
                        if (!r_have_prev) begin
                            r_prev      <= w_aligned;
                            r_have_prev <= 1'b1;
                        end else if (w_aligned == r_prev + 8'd1) begin
                            r_match_cnt <= w_match_inc;
                            r_prev      <= w_aligned;
                            if (w_match_inc == 8'(LOCK_THRESH - 1)) begin
                                r_state    <= StLocked;
                                r_expected <= w_aligned + 8'd1;
                                r_miss_cnt <= 8'd0;
                            end
                        end else begin
                            // Drop this word and retry the next rotation from scratch.
                            r_match_cnt <= 8'd0;
                            r_have_prev <= 1'b0;
                            r_rot       <= r_rot + 3'd1;
                        end
                    end
                    StLocked: begin
                        r_expected <= r_expected + 8'd1;
                        if (w_aligned == r_expected) begin
                            r_miss_cnt <= 8'd0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            r_word_err  <= w_word_next;
                            r_bit_err   <= w_bit_next;
                            r_miss_cnt  <= w_miss_inc;
                            if (w_miss_inc == 8'(UNLOCK_THRESH)) begin
                                r_state     <= StSearch;
                                r_have_prev <= 1'b0;
                                r_match_cnt <= 8'd0;
                                if (r_lock_loss != 8'hFF) begin
                                    r_lock_loss <= r_lock_loss + 8'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (i_clear) begin
                r_word_err  <= '0;
                r_bit_err   <= '0;
                r_lock_loss <= 8'd0;
            end
        end
    end

    assign o_locked        = (r_state == StLocked);
    assign o_rot           = r_rot;
    assign o_word_err_cnt  = r_word_err;
    assign o_bit_err_cnt   = r_bit_err;
    assign o_lock_loss_cnt = r_lock_loss;
    assign o_err_pulse     = r_err_pulse;

endmodule

// File: doc/counter_datachk.md
# counter_datachk

Receive-side pattern checker for the loopback path: the reading end of the 8-bit incrementing counter stream produced by the transmit-side counter data source. It consumes the 8-bit deserialized words delivered by the receive I/O, finds the bit rotation that aligns them to the counter sequence, and reports lock state, alignment, and word and bit error counts for ILA probing. It runs entirely in the fabric clock domain that reads the receive FIFO.

## Interface
Parameters:
- LOCK_THRESH, 16: consecutive in-sequence words required to declare lock (legal 2..255).
- UNLOCK_THRESH, 4: consecutive mismatching words in LOCKED that force a return to SEARCH (legal 1..255).
- ERR_W, 16: width of error counters.

Ports:
- clk  input  1  fabric clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- data_valid  input  1  data_in carries a word this cycle.
- data_in  input  8  raw received word.
- clear  input  1  synchronous clear of error counters and lock_loss_cnt; does not affect state.
- locked  output  1  high in LOCKED state.
- rot  output  3  current rotate-left amount applied to data_in.
- word_err_cnt  output  ERR_W  mismatching words while LOCKED, saturating.
- bit_err_cnt  output  ERR_W  sum of mismatching bits while LOCKED, saturating.
- lock_loss_cnt  output  8  LOCKED->SEARCH transitions, saturating at 255.
- err_pulse  output  1  one-cycle pulse per mismatching word while LOCKED.

## Operation
- aligned = data_in rotated left by rot (rot=0: unchanged; rot=3: {data_in[4:0],data_in[7:5]}).
- Only cycles with data_valid=1 advance anything; data_valid=0 holds every register (err_pulse low).
- Reset: state SEARCH, rot=0, have_prev=0, match_cnt=0, miss_cnt=0, expected=0, all counters 0, locked=0, err_pulse=0.
- SEARCH:
  - have_prev=0: prev <= aligned, have_prev <= 1.
  - have_prev=1 and aligned == prev+1 (mod 256): match_cnt++, prev <= aligned. When match_cnt reaches LOCK_THRESH-1 on this word: go LOCKED, expected <= aligned+1, miss_cnt <= 0.
  - have_prev=1 and mismatch: match_cnt <= 0, have_prev <= 0, rot <= rot+1 (7 wraps to 0).
- LOCKED:
  - aligned == expected: miss_cnt <= 0.
  - mismatch: err_pulse=1, word_err_cnt++, bit_err_cnt += popcount(aligned ^ expected) (0..8), miss_cnt++. If miss_cnt reaches UNLOCK_THRESH on this word: go SEARCH, have_prev=0, match_cnt=0, lock_loss_cnt++; rot unchanged.
  - expected <= expected+1 every valid word regardless of match (free-running, 255 wraps to 0).
- Counters saturate at all-ones; bit_err_cnt addition clamps to all-ones, never wraps.
- clear=1 zeroes word_err_cnt, bit_err_cnt, lock_loss_cnt; takes priority over a same-cycle increment. State, rot, expected unaffected.
- Counters do not increment in SEARCH.

## Timing
- All outputs registered; a valid word at edge N is reflected in locked/rot/counters/err_pulse after edge N.
- Lock latency from first in-sequence word at correct rot: LOCK_THRESH valid words.
- Worst-case acquisition: 8 rotations x (LOCK_THRESH+1) valid words, provided stream is clean.
- Unlock: exactly UNLOCK_THRESH consecutive mismatching valid words; the UNLOCK_THRESH-th is counted as an error and pulses err_pulse, locked falls the same edge.
- rst asserted mid-operation returns immediately to reset values; no partial update completes.

## Test plan
- Clean stream 0x00,0x01,... every cycle, LOCK_THRESH=16 -> locked rises after 16th word, rot=0, all error counters 0 over 1000 words.
- Stream rotated right by 3 before input -> locked with rot=3 within 8x17 words; counters stay 0 after lock.
- Locked; inject single word with bit 0 flipped -> err_pulse one cycle, word_err_cnt=1, bit_err_cnt=1, locked stays 1; next word 0xFF^expected -> word_err_cnt=2, bit_err_cnt=9.
- Locked; 4 consecutive corrupted words (UNLOCK_THRESH=4) -> locked falls on 4th, lock_loss_cnt=1, word_err_cnt=4; clean stream resumes -> relock at same rot.
- data_valid toggled 1/0 randomly on clean stream -> lock after 16 valid words, no errors; ERR_W=4 with 20 errors -> word_err_cnt holds 15.
- clear asserted together with an error word -> counters read 0 next cycle; rst mid-SEARCH -> rot=0, locked=0 immediately.
